// File: rtl/freq_meter.sv
// freq_meter: synchronizes a free-running square wave and counts its rising
// edges over a fixed gate window, reporting frequency, band and activity.
module freq_meter #(
    parameter int CLK_FREQ       = 27000000,
    parameter int GATE_CYCLES    = CLK_FREQ,
    parameter int TIMEOUT_CYCLES = CLK_FREQ,
    parameter int CNT_W          = 16,
    parameter int TARGET_FREQ    = 90,
    parameter int TOLERANCE      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             in_band,
    output logic             overflow,
    output logic             signal_active
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_PRE  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam int BAND_LO_I =
        (TARGET_FREQ > TOLERANCE) ? TARGET_FREQ - TOLERANCE : 0;
    localparam logic [31:0] BAND_LO = 32'(BAND_LO_I);
    localparam logic [31:0] BAND_HI = 32'(TARGET_FREQ + TOLERANCE);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t state, state_d;

    logic              sync1, sync2, prev, rise;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_count, freq_next;
    logic [31:0]       freq_wide;
    logic [IDLE_W-1:0] idle_cnt;
    logic              ovf, sat, terminal, in_band_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    state_d = ARM;
                ARM:     if (rise) state_d = MEASURE;
                MEASURE: state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign terminal = en && (state == MEASURE) && (gate_cnt == GATE_LAST);

    // A rise on the terminal cycle is folded into the closing window.
    always_comb begin
        sat       = rise && (edge_count == CNT_MAX);
        freq_next = edge_count;
        if (rise && !sat) freq_next = edge_count + 1'b1;
    end

    assign freq_wide    = 32'(freq_next);
    assign in_band_next = (freq_wide >= BAND_LO) && (freq_wide <= BAND_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt   <= '0;
            edge_count <= '0;
            ovf        <= 1'b0;
        end else if (!en || state == IDLE) begin
            gate_cnt   <= '0;
            edge_count <= '0;
            ovf        <= 1'b0;
        end else if (state == ARM) begin
            if (rise) begin
                gate_cnt   <= GATE_W'(1);
                edge_count <= CNT_W'(1);
            end
        end else if (terminal) begin
            gate_cnt   <= '0;
            edge_count <= '0;
            ovf        <= 1'b0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise) begin
                if (edge_count == CNT_MAX) ovf <= 1'b1;
                else edge_count <= edge_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_out   <= '0;
            freq_valid <= 1'b0;
            in_band    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= terminal;
            if (terminal) begin
                freq_out <= freq_next;
                in_band  <= in_band_next;
                overflow <= ovf | sat;
            end
        end
    end

    // Activity watchdog runs regardless of state; a fresh rise always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt      <= '0;
            signal_active <= 1'b0;
        end else if (rise) begin
            idle_cnt      <= '0;
            signal_active <= 1'b1;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDLE_PRE) signal_active <= 1'b0;
        end
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Downstream monitor for the square-wave generator output: synchronizes a free-running square wave and counts its rising edges over a fixed gate window.
- Reports the measured frequency once per window, with in-band and activity status.
- Used on the 27 MHz board clock to confirm that the stimulus tone is present and on-frequency before downstream vision/actuation logic acts on it.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz; default source for GATE_CYCLES and TIMEOUT_CYCLES.
- GATE_CYCLES, 27000000, gate window length in clk cycles (1 s at default; the bench overrides it).
- TIMEOUT_CYCLES, 27000000, cycles without a rising edge before signal_active drops.
- CNT_W, 16, width of the edge counter and freq_out.
- TARGET_FREQ, 90, expected edge count per window.
- TOLERANCE, 2, allowed ± deviation from TARGET_FREQ for in_band.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  asynchronous square wave to measure.
- freq_out  output  CNT_W  rising edges counted in last completed window.
- freq_valid  output  1  one-cycle pulse when freq_out updates.
- in_band  output  1  registered: |freq_out − TARGET_FREQ| ≤ TOLERANCE.
- overflow  output  1  last completed window saturated the counter.
- signal_active  output  1  a rising edge was seen within the last TIMEOUT_CYCLES.

Behaviour:
- Reset (asynchronous, any time):
  - All outputs go to 0.
  - Synchronizer flops, edge_count, gate_cnt and idle_cnt clear; state = IDLE.
  - Reset mid-window discards the partial count; no freq_valid is issued.
- Input path and latency:
  - 2-flop synchronizer, then a registered previous-value flop.
  - rise = sync2 & ~prev.
  - A 0→1 on sig_in that meets setup produces rise 3 clk edges later.
- States:
  - IDLE: counters held at 0. Go to ARM when en=1.
  - ARM: wait for the first rise. On rise, go to MEASURE with gate_cnt=1 and edge_count=1; the arming edge is counted.
  - MEASURE:
    - gate_cnt increments every cycle; edge_count increments on rise and saturates at 2^CNT_W−1 (sets the internal ovf flag).
    - On the cycle gate_cnt == GATE_CYCLES−1:
      - freq_out ← edge_count + rise (saturating) and freq_valid=1 for that cycle; overflow ← ovf-or-saturation; in_band is registered in the same cycle from the new value.
      - Then gate_cnt ← 0, edge_count ← 0, ovf ← 0. A rise on this terminal cycle belongs to the closing window.
      - The next window starts immediately, with no re-arm.
  - Any state: en=0 → IDLE next cycle. Partial window discarded; freq_out, in_band and overflow hold their last values; no freq_valid.
- Activity detection, independent of state except reset:
  - idle_cnt clears on rise, otherwise increments and saturates at TIMEOUT_CYCLES.
  - signal_active ← 1 on the cycle after rise.
  - signal_active ← 0 when idle_cnt reaches TIMEOUT_CYCLES.
  - A rise on that same cycle wins: signal_active stays 1.
- Widths and arithmetic:
  - gate_cnt and idle_cnt widths are $clog2 of their limits.
  - in_band compare is unsigned, done as a two-sided range check (no subtraction underflow).
  - A zero-edge window is impossible in MEASURE, but a window with 1 edge reports 1.
- A constant-high or constant-low sig_in never leaves ARM: freq_valid is never issued and signal_active drops after the timeout.

Test Plan:
- Bench parameter override for all scenarios: GATE_CYCLES=1000, TIMEOUT_CYCLES=300, TARGET_FREQ=10, TOLERANCE=1, CNT_W=8.
- Reset, then en=1, sig_in period 100 cycles (50 high / 50 low) → freq_valid pulses every 1000 cycles after the arming edge; freq_out=10; in_band=1; overflow=0; signal_active=1.
- Period 80 cycles → freq_out=13 (edges at 0, 80, …, 960), in_band=0. Period 111 cycles → freq_out=10, in_band=1.
- Period 2 cycles (toggle each clk) → 500 edges exceed 255: freq_out=255, overflow=1, in_band=0. Switching to period 100 → next window gives overflow=0.
- Stop sig_in low mid-window → signal_active falls exactly 300 cycles after the last rise. The window still completes with the partial count. Restarting the toggle → signal_active=1 on the cycle after the first rise.
- en=0 at gate_cnt=500 → no freq_valid; freq_out holds the previous value. en=1 again → ARM; first freq_valid 1000 cycles after the next rise.
- Assert rst mid-window and at the terminal cycle → all outputs 0 asynchronously; no freq_valid on the reset cycle.
